// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: request/response handshakes for the fetch and data ports plus the ROM address/data pair.
interface rom_arbiter_if #(parameter int ADDR_WIDTH = 12, parameter int DATA_WIDTH = 16);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic                  fetch_ack;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_valid;
  logic                  data_req;
  logic [ADDR_WIDTH-1:0] data_address;
  logic                  data_ack;
  logic [DATA_WIDTH-1:0] data_data;
  logic                  data_valid;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  busy;
  modport master (
    output fetch_req, fetch_address, data_req, data_address, rom_data,
    input  fetch_ack, fetch_data, fetch_valid, data_ack, data_data, data_valid, rom_address, busy
  );
  modport slave (
    input  fetch_req, fetch_address, data_req, data_address, rom_data,
    output fetch_ack, fetch_data, fetch_valid, data_ack, data_data, data_valid, rom_address, busy
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one registered-read ROM between fetch and data requesters, one read per 3 cycles.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed fetch-first priority.
module rom_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  rom_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state;
  logic   owner;
  logic   win_data;
`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic   last_grant;
  always_comb win_data = bus.data_req & (~bus.fetch_req | ~last_grant);
`else
  always_comb win_data = ~bus.fetch_req;
`endif
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      owner           <= 1'b0;
      bus.fetch_ack   <= 1'b0;
      bus.data_ack    <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.data_valid  <= 1'b0;
      bus.fetch_data  <= '0;
      bus.data_data   <= '0;
      bus.rom_address <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_grant      <= 1'b1;
`endif
    end else begin
      bus.fetch_ack   <= 1'b0;
      bus.data_ack    <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.data_valid  <= 1'b0;
      case (state)
        IDLE: if (bus.fetch_req | bus.data_req) begin
          bus.rom_address <= win_data ? bus.data_address : bus.fetch_address;
          owner           <= win_data;
          bus.fetch_ack   <= ~win_data;
          bus.data_ack    <= win_data;
          state           <= ISSUE;
`ifdef ROM_ARB_ROUND_ROBIN_EN
          last_grant      <= win_data;
`endif
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          if (owner) begin
            bus.data_data  <= bus.rom_data;
            bus.data_valid <= 1'b1;
          end else begin
            bus.fetch_data  <= bus.rom_data;
            bus.fetch_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
